ioctl_stream_tx: RTL and testbench
==================================

Name: ioctl_stream_tx

Overview:
Transmitter side of the ioctl download bus. It replays a byte image from a local source memory onto ioctl_download/ioctl_index/ioctl_wr/ioctl_addr/ioctl_dout. The pacing and framing match what the existing download receivers expect: ROM dprams, the mod-select byte and DIP capture. Uses: in-core ROM/DIP re-injection (e.g. a restore after a mod change) and a bench driver for the download sinks.

Parameters:
ADDR_W, 25, width of ioctl_addr and base
SRC_AW, 16, source memory address width; length is SRC_AW+1 bits
GAP, 7, idle cycles after each ioctl_wr pulse (min 1)

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  request pulse; accepted only in IDLE
index  in  8  ioctl_index for the transfer; latched on accept
base  in  ADDR_W  first ioctl_addr; latched on accept
length  in  SRC_AW+1  byte count; latched on accept; 0 = empty transfer
hold  in  1  stall request; honoured only at the end of GAP
busy  out  1  high from accept until return to IDLE
done  out  1  one-cycle pulse at normal completion
src_rd  out  1  source read strobe
src_addr  out  SRC_AW  source byte address (0..length-1)
src_data  in  8  source data, valid the cycle after src_rd
ioctl_download  out  1  transfer frame
ioctl_index  out  8  latched index
ioctl_wr  out  1  one-cycle write strobe per byte
ioctl_addr  out  ADDR_W  base+n
ioctl_dout  out  8  byte n

Behaviour:
- All outputs are registered. Reset value of every output is 0.
- Reset mid-transfer: all outputs are 0 on the next cycle. No done pulse. FSM returns to IDLE.
- FSM states: IDLE, SETUP, READ, CAPTURE, WRITE, GAP, FINISH.
- IDLE:
  - start=1 with length!=0: latch index/base/length, set n=0, go to SETUP.
  - start=1 with length=0: go to FINISH directly; download never asserts.
- SETUP: ioctl_download=1, ioctl_index valid. Always 1 cycle. Go to READ.
- READ: src_rd=1, src_addr=n. Go to CAPTURE.
- CAPTURE: ioctl_dout<=src_data, ioctl_addr<=base+n. Go to WRITE.
- WRITE: ioctl_wr=1 for exactly 1 cycle. dout/addr were already stable the cycle before. Go to GAP.
- GAP:
  - Count GAP cycles; ioctl_wr=0; addr/dout held.
  - After the count, if hold=1, stay in GAP with addr/dout held.
  - Otherwise n<=n+1; go to READ if n+1<length, else FINISH.
- FINISH:
  - ioctl_download=0, done=1 for one cycle, busy=0 next cycle, return to IDLE.
  - Index/addr/dout keep their last values until the next accept.
- Cycle timing, accept edge = cycle 0:
  - download rises cycle 1; src_rd cycle 2; first ioctl_wr cycle 4.
  - Byte period is GAP+3 cycles with hold=0.
  - For length L, done pulses at cycle 4+(L-1)(GAP+3)+GAP+1.
- busy=1 from cycle 1 through FINISH. A start while busy is ignored, including in the FINISH cycle.
- Arithmetic: ioctl_addr=base+n modulo 2^ADDR_W (wraps). src_addr=n[SRC_AW-1:0]. n is SRC_AW+1 bits, so length=2^SRC_AW is legal.
- ioctl_download stays high through all GAP/hold periods. It never drops between bytes of one transfer.

Decomposition:
- Shared package ioctl_tx_pkg holds:
  - state enum;
  - index constants IDX_ROM=0, IDX_MOD=1, IDX_DIP=254;
  - DIP_LEN=8.
- No sub-module. The GAP counter is an inline down-counter.
- Expected RTL size: about 150 lines.

Test Plan:
1. index=0, base=0, length=4, src=A0,A1,A2,A3, GAP=7 -> ioctl_wr at cycles 4,14,24,34 with addr 0..3 and dout A0..A3; download high cycles 1..41; done at cycle 42; ROM dpram reads back A0..A3.
2. index=254, base=0, length=8, src=11..18 -> DIP array sw[0..7] holds 11..18; ioctl_index=254 through the whole transfer.
3. length=0 -> done at cycle 1, download and wr never assert, busy=0 throughout.
4. length=3, hold=1 for 20 cycles starting at the end of byte 0's GAP -> second ioctl_wr at cycle 34 instead of 14; addr=0/dout=byte0 held during the hold; total bytes=3.
5. length=4, reset asserted at cycle 20 -> cycle 21: download=0, wr=0, busy=0, no done; a new start at cycle 25 sends byte 0 at addr=base.
6. base=0x1FFFFFE, length=3, plus a start pulse at cycle 10 -> addrs 0x1FFFFFE, 0x1FFFFFF, 0x0000000; the second start has no effect (length and base stay unchanged).

Source files
------------

// File: rtl/ioctl_tx_pkg.sv
// Shared types and constants for the ioctl download transmitter.
package ioctl_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_READ,
      ST_CAPTURE,
      ST_WRITE,
      ST_GAP,
      ST_FINISH
   } state_t;

   // ioctl_index values understood by the download receivers
   localparam logic [7:0] IDX_ROM = 8'd0;
   localparam logic [7:0] IDX_MOD = 8'd1;
   localparam logic [7:0] IDX_DIP = 8'd254;

   // DIP switch image is always eight bytes
   localparam int DIP_LEN = 8;

endpackage

// File: rtl/ioctl_stream_tx.sv
// Replays a byte image from a local source memory onto the ioctl download
// bus with the framing and pacing the existing download receivers expect.
// Every output is a register; it is loaded from the next-state decode so the
// outputs line up with the state the FSM occupies in the same cycle.
module ioctl_stream_tx
   import ioctl_tx_pkg::*;
#(
   parameter int ADDR_W = 25,
   parameter int SRC_AW = 16,
   parameter int GAP    = 7
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        index,
   input  logic [ADDR_W-1:0] base,
   input  logic [SRC_AW:0]   length,
   input  logic              hold,
   output logic              busy,
   output logic              done,
   output logic              src_rd,
   output logic [SRC_AW-1:0] src_addr,
   input  logic [7:0]        src_data,
   output logic              ioctl_download,
   output logic [7:0]        ioctl_index,
   output logic              ioctl_wr,
   output logic [ADDR_W-1:0] ioctl_addr,
   output logic [7:0]        ioctl_dout
);

   localparam int LEN_W = SRC_AW + 1;
   localparam int CNT_W = (GAP > 1) ? $clog2(GAP + 1) : 1;

   state_t            state, next_state;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  n;
   logic [LEN_W-1:0]  n_inc;
   logic [ADDR_W-1:0] base_q;
   logic [CNT_W-1:0]  gap_cnt;
   logic              accept;

   assign n_inc  = n + LEN_W'(1);
   assign accept = start && (state == ST_IDLE) && (length != '0);

   // State register
   always_ff @(posedge clk_sys) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process evaluation order.
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   // Next-state decode; byte loop is READ -> CAPTURE -> WRITE -> GAP
   always_comb begin
      // NOTE: default assigned first so no path through the case infers a latch.
      next_state = state;
      case (state)
         ST_IDLE:    if (start) next_state = (length == '0) ? ST_FINISH : ST_SETUP;
         ST_SETUP:   next_state = ST_READ;
         ST_READ:    next_state = ST_CAPTURE;
         ST_CAPTURE: next_state = ST_WRITE;
         ST_WRITE:   next_state = ST_GAP;
         ST_GAP: begin
            // hold is only looked at once the gap count has run out
            if ((gap_cnt == '0) && !hold)
               next_state = (n_inc < len_q) ? ST_READ : ST_FINISH;
         end
         ST_FINISH:  next_state = ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase
   end

   // Transfer context, gap counter and registered bus outputs
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         len_q          <= '0;
         base_q         <= '0;
         n              <= '0;
         gap_cnt        <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         src_rd         <= 1'b0;
         src_addr       <= '0;
         ioctl_download <= 1'b0;
         ioctl_index    <= '0;
         ioctl_wr       <= 1'b0;
         ioctl_addr     <= '0;
         ioctl_dout     <= '0;
      end else begin
         if (accept) begin
            len_q       <= length;
            base_q      <= base;
            ioctl_index <= index;
            n           <= '0;
         end

         // gap down-counter: loaded leaving WRITE, sits at zero while held
         if (state == ST_WRITE)
            gap_cnt <= CNT_W'(GAP - 1);
         else if ((state == ST_GAP) && (gap_cnt != '0))
            gap_cnt <= gap_cnt - CNT_W'(1);

         if ((state == ST_GAP) && (next_state == ST_READ))
            n <= n_inc;

         src_rd <= (next_state == ST_READ);
         if (next_state == ST_READ)
            src_addr <= (state == ST_GAP) ? n_inc[SRC_AW-1:0] : n[SRC_AW-1:0];

         // source data arrives during CAPTURE; address wraps at ADDR_W bits
         if (state == ST_CAPTURE) begin
            ioctl_dout <= src_data;
            ioctl_addr <= base_q + ADDR_W'(n);
         end

         ioctl_wr       <= (next_state == ST_WRITE);
         ioctl_download <= (next_state inside {ST_SETUP, ST_READ, ST_CAPTURE, ST_WRITE, ST_GAP});
         done           <= (next_state == ST_FINISH);
         // an empty transfer goes straight from IDLE to FINISH and never shows busy
         busy           <= (next_state != ST_IDLE) &&
                           !((state == ST_IDLE) && (next_state == ST_FINISH));
      end
   end

endmodule

// File: tb/tb_ioctl_stream_tx.sv
// Directed bench for ioctl_stream_tx with a source RAM model and simple
// ROM / DIP download sinks. Cycle k is counted from the cycle in which start
// is presented (cycle 0); the accept edge ends cycle 0.
module tb_ioctl_stream_tx;
   import ioctl_tx_pkg::*;

   logic        clk_sys = 1'b0;
   logic        reset, start, hold;
   logic [7:0]  index;
   logic [24:0] base;
   logic [16:0] length;
   logic        busy, done, src_rd;
   logic [15:0] src_addr;
   logic [7:0]  src_data;
   logic        ioctl_download, ioctl_wr;
   logic [7:0]  ioctl_index, ioctl_dout;
   logic [24:0] ioctl_addr;

   ioctl_stream_tx #(.ADDR_W(25), .SRC_AW(16), .GAP(7)) dut (
      .clk_sys(clk_sys), .reset(reset), .start(start), .index(index),
      .base(base), .length(length), .hold(hold), .busy(busy), .done(done),
      .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
      .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout)
   );

   always #5 clk_sys = ~clk_sys;

   // Source memory: registered read, data valid the cycle after src_rd
   logic [7:0] mem [0:255];
   always @(posedge clk_sys) if (src_rd) src_data <= mem[src_addr[7:0]];

   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   // Event log for the current transfer
   int          t0;
   int          wr_cyc[$];
   logic [31:0] wr_addr[$];
   logic [7:0]  wr_dout[$];
   int          done_cyc[$];
   int          dl_first, dl_last, dl_cnt, rd_first;
   bit          busy_seen, idx_bad;
   logic [7:0]  exp_idx;
   logic [7:0]  rom [0:255];
   logic [7:0]  sw  [0:DIP_LEN-1];
   logic        snap_dl, snap_wr, snap_busy;
   logic [24:0] snap_addr;
   logic [7:0]  snap_dout;

   // Bus monitor plus ROM dpram / DIP capture sinks
   always @(negedge clk_sys) begin
      if (ioctl_wr) begin
         wr_cyc.push_back(cyc - t0);
         wr_addr.push_back(32'(ioctl_addr));
         wr_dout.push_back(ioctl_dout);
         if (ioctl_index == IDX_ROM) rom[ioctl_addr[7:0]] = ioctl_dout;
         if (ioctl_index == IDX_DIP) sw[ioctl_addr[2:0]]  = ioctl_dout;
      end
      if (done) done_cyc.push_back(cyc - t0);
      if (src_rd && rd_first < 0) rd_first = cyc - t0;
      if (ioctl_download) begin
         if (dl_first < 0) dl_first = cyc - t0;
         dl_last = cyc - t0;
         dl_cnt++;
         if (ioctl_index != exp_idx) idx_bad = 1'b1;
      end
      if (busy) busy_seen = 1'b1;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present start for one cycle (cycle 0) and clear the log
   task automatic start_xfer(input logic [7:0] idx, input logic [24:0] b, input logic [16:0] len);
      @(negedge clk_sys);
      wr_cyc.delete(); wr_addr.delete(); wr_dout.delete(); done_cyc.delete();
      dl_first = -1; dl_last = -1; dl_cnt = 0; rd_first = -1;
      busy_seen = 1'b0; idx_bad = 1'b0;
      t0 = cyc; exp_idx = idx;
      index = idx; base = b; length = len; start = 1'b1;
   endtask

   // Step cycles 1..ncyc with optional hold window, reset pulse, second start
   // (with different base/length) and a snapshot of the bus at one cycle
   task automatic run(input int ncyc, input int hold_from, input int hold_to,
                      input int rst_at, input int restart_at, input int snap_at);
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk_sys);
         start = (k == restart_at);
         hold  = (k >= hold_from) && (k <= hold_to);
         reset = (k == rst_at);
         if (k == restart_at) begin
            base   = 25'h0000123;
            length = 17'd5;
         end
         if (k == snap_at) begin
            snap_dl = ioctl_download; snap_wr = ioctl_wr; snap_busy = busy;
            snap_addr = ioctl_addr;   snap_dout = ioctl_dout;
         end
      end
   endtask

   task automatic check_wr(input string tag, input int i, input int exp_cyc,
                           input logic [31:0] exp_addr, input logic [7:0] exp_dout);
      check($sformatf("%s wr%0d cycle", tag, i), (i < wr_cyc.size())  ? wr_cyc[i]  : -1, exp_cyc);
      check($sformatf("%s wr%0d addr", tag, i),  (i < wr_addr.size()) ? wr_addr[i] : 32'hDEAD_BEEF, exp_addr);
      check($sformatf("%s wr%0d dout", tag, i),  (i < wr_dout.size()) ? 32'(wr_dout[i]) : 32'hDEAD_BEEF, 32'(exp_dout));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; hold = 1'b0;
      index = '0; base = '0; length = '0;
      t0 = 0; exp_idx = '0;
      dl_first = -1; dl_last = -1; dl_cnt = 0; rd_first = -1;
      for (int i = 0; i < 256; i++) begin mem[i] = 8'(i) ^ 8'h5A; rom[i] = 8'h00; end
      for (int i = 0; i < DIP_LEN; i++) sw[i] = 8'h00;
      repeat (3) @(negedge clk_sys);

      // Reset state
      check("rst busy", 32'(busy), 0);
      check("rst done", 32'(done), 0);
      check("rst download", 32'(ioctl_download), 0);
      check("rst wr", 32'(ioctl_wr), 0);
      check("rst src_rd", 32'(src_rd), 0);
      check("rst addr", 32'(ioctl_addr), 0);
      check("rst index", 32'(ioctl_index), 0);
      reset = 1'b0;

      // 1: ROM image of four bytes
      for (int i = 0; i < 4; i++) mem[i] = 8'hA0 + 8'(i);
      start_xfer(IDX_ROM, 25'h0, 17'd4);
      run(50, 0, -1, -1, -1, 42);
      check("t1 wr count", wr_cyc.size(), 4);
      for (int i = 0; i < 4; i++) check_wr("t1", i, 4 + 10 * i, i, 8'hA0 + 8'(i));
      check("t1 src_rd first", rd_first, 2);
      check("t1 download first", dl_first, 1);
      check("t1 download last", dl_last, 41);
      check("t1 download cycles", dl_cnt, 41);
      check("t1 done count", done_cyc.size(), 1);
      check("t1 done cycle", (done_cyc.size() > 0) ? done_cyc[0] : -1, 42);
      check("t1 busy in finish", 32'(snap_busy), 1);
      for (int i = 0; i < 4; i++) check($sformatf("t1 rom[%0d]", i), 32'(rom[i]), 32'hA0 + i);

      // 2: DIP image, index must stay 254 for the whole frame
      for (int i = 0; i < 8; i++) mem[i] = 8'h11 + 8'(i);
      start_xfer(IDX_DIP, 25'h0, 17'd8);
      run(90, 0, -1, -1, -1, -1);
      check("t2 wr count", wr_cyc.size(), 8);
      for (int i = 0; i < DIP_LEN; i++) check($sformatf("t2 sw[%0d]", i), 32'(sw[i]), 32'h11 + i);
      check("t2 index stable", 32'(idx_bad), 0);
      check("t2 done cycle", (done_cyc.size() > 0) ? done_cyc[0] : -1, 82);

      // 3: empty transfer
      start_xfer(IDX_ROM, 25'h40, 17'd0);
      run(10, 0, -1, -1, -1, -1);
      check("t3 done count", done_cyc.size(), 1);
      check("t3 done cycle", (done_cyc.size() > 0) ? done_cyc[0] : -1, 1);
      check("t3 download cycles", dl_cnt, 0);
      check("t3 wr count", wr_cyc.size(), 0);
      check("t3 busy seen", 32'(busy_seen), 0);

      // 4: hold for 20 cycles from the last gap cycle of byte 0
      for (int i = 0; i < 3; i++) mem[i] = 8'h40 + 8'(i);
      start_xfer(IDX_ROM, 25'h0, 17'd3);
      run(60, 11, 30, -1, -1, 20);
      check("t4 wr count", wr_cyc.size(), 3);
      check_wr("t4", 0, 4, 0, 8'h40);
      check_wr("t4", 1, 34, 1, 8'h41);
      check_wr("t4", 2, 44, 2, 8'h42);
      check("t4 held addr", 32'(snap_addr), 0);
      check("t4 held dout", 32'(snap_dout), 32'h40);
      check("t4 held wr", 32'(snap_wr), 0);
      check("t4 held download", 32'(snap_dl), 1);
      check("t4 download cycles", dl_cnt, 51);
      check("t4 done cycle", (done_cyc.size() > 0) ? done_cyc[0] : -1, 52);

      // 5: reset mid-transfer, then a fresh transfer
      for (int i = 0; i < 4; i++) mem[i] = 8'hC0 + 8'(i);
      start_xfer(IDX_ROM, 25'h100, 17'd4);
      run(24, 0, -1, 20, -1, 21);
      check("t5 download after reset", 32'(snap_dl), 0);
      check("t5 wr after reset", 32'(snap_wr), 0);
      check("t5 busy after reset", 32'(snap_busy), 0);
      check("t5 no done", done_cyc.size(), 0);
      check("t5 download last", dl_last, 20);
      start_xfer(IDX_ROM, 25'h100, 17'd4);
      run(50, 0, -1, -1, -1, -1);
      check("t5 wr count", wr_cyc.size(), 4);
      check_wr("t5", 0, 4, 32'h100, 8'hC0);
      check("t5 done cycle", (done_cyc.size() > 0) ? done_cyc[0] : -1, 42);

      // 6: address wrap, second start while busy is ignored
      for (int i = 0; i < 8; i++) mem[i] = 8'h70 + 8'(i);
      start_xfer(IDX_ROM, 25'h1FFFFFE, 17'd3);
      run(45, 0, -1, -1, 10, -1);
      check("t6 wr count", wr_cyc.size(), 3);
      check_wr("t6", 0, 4, 32'h1FFFFFE, 8'h70);
      check_wr("t6", 1, 14, 32'h1FFFFFF, 8'h71);
      check_wr("t6", 2, 24, 32'h0000000, 8'h72);
      check("t6 done count", done_cyc.size(), 1);
      check("t6 done cycle", (done_cyc.size() > 0) ? done_cyc[0] : -1, 32);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
